uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a go/acknowledge handshake toward the I/O block.
// Optional stop-bit framing check enabled by defining UART_RX_FRAMING_CHECK_EN.
module uart_rx #(
    parameter int ClockFrequencyHz = 20_250_000,
    parameter int BaudRate         = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       go,
    output logic [7:0] data,
    output logic       data_ready
);

    // state      | meaning
    // IDLE       | line idle, waiting for a start edge while go=1
    // START_BIT  | timing to the middle of the start bit to reject glitches
    // DATA_BITS  | sampling 8 data bits at mid-bit, shifting in LSB first
    // STOP_BIT   | timing to the middle of the stop bit
    // WAIT_ACK   | byte held with data_ready=1 until go drops
    // BREAK_WAIT | framing error seen; waiting for the line to return high

    localparam int BitDuration = ClockFrequencyHz / BaudRate;  // must be >= 8
    localparam int TimerWidth  = $clog2(BitDuration) + 1;

    localparam logic [TimerWidth-1:0] HalfLoad = TimerWidth'(BitDuration / 2 - 1);
    localparam logic [TimerWidth-1:0] FullLoad = TimerWidth'(BitDuration - 1);
    localparam logic [TimerWidth-1:0] TimerOne = TimerWidth'(1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        WAIT_ACK,
        BREAK_WAIT
    } state_t;

    state_t                  state;
    logic [TimerWidth-1:0]   timer;
    logic [3:0]              bit_count;
    logic                    rx_meta;
    logic                    rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_count  <= 4'd0;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            data       <= 8'h00;
            data_ready <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            case (state)
                IDLE: begin
                    if (go && !rx_s) begin
                        timer <= HalfLoad;
                        state <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (timer != '0) begin
                        timer <= timer - TimerOne;
                    end else if (!rx_s) begin
                        timer     <= FullLoad;
                        bit_count <= 4'd0;
                        data      <= 8'h00;
                        state     <= DATA_BITS;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA_BITS: begin
                    if (timer != '0) begin
                        timer <= timer - TimerOne;
                    end else begin
                        data      <= {rx_s, data[7:1]};
                        bit_count <= bit_count + 4'd1;
                        timer     <= FullLoad;
                        if (bit_count == 4'd7) begin
                            state <= STOP_BIT;
                        end
                    end
                end
                STOP_BIT: begin
                    if (timer != '0) begin
                        timer <= timer - TimerOne;
                    end else begin
`ifdef UART_RX_FRAMING_CHECK_EN
                        if (!rx_s) begin
                            state <= BREAK_WAIT;
                        end else begin
                            data_ready <= 1'b1;
                            state      <= WAIT_ACK;
                        end
`else
                        data_ready <= 1'b1;
                        state      <= WAIT_ACK;
`endif
                    end
                end
                WAIT_ACK: begin
                    if (!go) begin
                        data_ready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BitDuration = 10 clocks.
// Frame stimulus is driven on falling clock edges; outputs sampled 1 time unit after rising edges.
module tb_uart_rx;

    localparam int Bd = 10;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       go;
    logic [7:0] data;
    logic       data_ready;

    int total = 0;
    int bad   = 0;

    uart_rx #(
        .ClockFrequencyHz(1_000_000),
        .BaudRate        (100_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .go        (go),
        .data      (data),
        .data_ready(data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Must be called at a falling edge; returns at a falling edge so frames can abut.
    task automatic send_frame(input logic [7:0] b, input logic stop_level);
        rx = 1'b0;
        repeat (Bd) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Bd) @(negedge clk);
        end
        rx = stop_level;
        repeat (Bd) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (data_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int errs;
        rst_n = 1'b0;
        rx    = 1'b1;
        go    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (data !== 8'h00 || data_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: data=%h ready=%b, want data=00 ready=0", data, data_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        errs  = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (data !== 8'h00 || data_ready !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_200: %0d cycles with data/ready nonzero, want 0", errs);
        end
    endtask

    task automatic test_single_frame;
        bit ok;
        int cycles;
        @(negedge clk);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_ready(130, ok, cycles);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL a5_ready: data_ready never rose within 130 cycles, want rise");
                end
                total++;
                if (cycles < 95 || cycles > 98) begin
                    bad++;
                    $display("FAIL a5_latency: got %0d cycles, want 95..98", cycles);
                end
                total++;
                if (data !== 8'hA5) begin
                    bad++;
                    $display("FAIL a5_data: got %h, want a5", data);
                end
                go = 1'b0;
                @(posedge clk);
                #1;
                go = 1'b1;
                total++;
                if (data_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL a5_ack: data_ready=%b after ack, want 0", data_ready);
                end
                total++;
                if (data !== 8'hA5) begin
                    bad++;
                    $display("FAIL a5_hold: data=%h after ack, want a5", data);
                end
            end
        join
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_bytes [2];
        exp_bytes[0] = 8'h41;
        exp_bytes[1] = 8'h0D;
        @(negedge clk);
        fork
            begin
                send_frame(8'h41, 1'b1);
                send_frame(8'h0D, 1'b1);
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    bit ok;
                    int cycles;
                    wait_ready(150, ok, cycles);
                    total++;
                    if (!ok || data !== exp_bytes[j]) begin
                        bad++;
                        $display("FAIL b2b_byte%0d: ready=%b data=%h, want ready=1 data=%h",
                                 j, ok, data, exp_bytes[j]);
                    end
                    go = 1'b0;
                    @(posedge clk);
                    #1;
                    go = 1'b1;
                end
            end
        join
    endtask

    task automatic test_glitch;
        int seen;
        bit ok;
        int cycles;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx   = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (data_ready) seen++;
        end
        total++;
        if (seen != 0 || data !== 8'h0D) begin
            bad++;
            $display("FAIL glitch_reject: ready cycles=%0d data=%h, want 0 cycles data=0d", seen, data);
        end
        @(negedge clk);
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_ready(130, ok, cycles);
                total++;
                if (!ok || data !== 8'h55) begin
                    bad++;
                    $display("FAIL glitch_next: ready=%b data=%h, want ready=1 data=55", ok, data);
                end
                go = 1'b0;
                @(posedge clk);
                #1;
                go = 1'b1;
            end
        join
    endtask

    task automatic test_go_low;
        int seen;
        bit ok;
        int cycles;
        @(negedge clk);
        go   = 1'b0;
        seen = 0;
        fork
            send_frame(8'h33, 1'b1);
            repeat (110) begin
                @(posedge clk);
                #1;
                if (data_ready) seen++;
            end
        join
        total++;
        if (seen != 0 || data !== 8'h55) begin
            bad++;
            $display("FAIL go_low_ignore: ready cycles=%0d data=%h, want 0 cycles data=55", seen, data);
        end
        repeat (5) @(negedge clk);
        go = 1'b1;
        repeat (5) @(negedge clk);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                wait_ready(130, ok, cycles);
                total++;
                if (!ok || data !== 8'h7E) begin
                    bad++;
                    $display("FAIL go_high_7e: ready=%b data=%h, want ready=1 data=7e", ok, data);
                end
                go = 1'b0;
                @(posedge clk);
                #1;
                go = 1'b1;
            end
        join
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int cycles;
        @(negedge clk);
        rx = 1'b0;
        repeat (Bd) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (Bd) @(negedge clk);
        end
        total++;
        if (data !== 8'hF0) begin
            bad++;
            $display("FAIL partial_shift: data=%h after 4 one-bits, want f0", data);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        total++;
        if (data !== 8'h00 || data_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: data=%h ready=%b, want data=00 ready=0", data, data_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_ready(130, ok, cycles);
                total++;
                if (!ok || data !== 8'hC3) begin
                    bad++;
                    $display("FAIL after_reset_c3: ready=%b data=%h, want ready=1 data=c3", ok, data);
                end
                go = 1'b0;
                @(posedge clk);
                #1;
                go = 1'b1;
            end
        join
    endtask

    task automatic test_framing;
        bit ok;
        int cycles;
        repeat (10) @(negedge clk);
`ifdef UART_RX_FRAMING_CHECK_EN
        begin
            int seen;
            seen = 0;
            fork
                send_frame(8'h5A, 1'b0);
                repeat (120) begin
                    @(posedge clk);
                    #1;
                    if (data_ready) seen++;
                end
            join
            total++;
            if (seen != 0) begin
                bad++;
                $display("FAIL framing_reject: ready high %0d cycles, want 0", seen);
            end
        end
`else
        fork
            send_frame(8'h5A, 1'b0);
            begin
                wait_ready(130, ok, cycles);
                total++;
                if (!ok || data !== 8'h5A) begin
                    bad++;
                    $display("FAIL stop_ignored: ready=%b data=%h, want ready=1 data=5a", ok, data);
                end
                go = 1'b0;
                @(posedge clk);
                #1;
                go = 1'b1;
            end
        join
`endif
        repeat (20) @(negedge clk);
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_ready(130, ok, cycles);
                total++;
                if (!ok || data !== 8'h96) begin
                    bad++;
                    $display("FAIL after_stop_96: ready=%b data=%h, want ready=1 data=96", ok, data);
                end
                go = 1'b0;
                @(posedge clk);
                #1;
                go = 1'b1;
            end
        join
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_go_low();
        test_reset_mid_frame();
        test_framing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
